// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART blocks: FSM encoding, default
// constants and the even-parity check.
package uart_pkg;

  localparam int         TICK_DIV_DEF  = 326;
  localparam int         OVS_DEF       = 16;
  localparam logic [7:0] IDLE_CHAR_DEF = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // 1 when data plus parity bit fail the even-parity rule.
  function automatic logic even_par_err(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: divides clk by TICK_DIV while ce is high; clr
// re-phases the counter so the next tick lands TICK_DIV enabled cycles later.
module uart_tick_gen #(
  parameter int TICK_DIV = 326
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (ce) begin
      if (clr || cnt == LAST)        cnt <= '0;
      else                           cnt <= cnt + 1'b1;
    end
  end

  assign tick = ce && (cnt == LAST);

endmodule

// File: rtl/uart_rx_ovs.sv
// 16x-oversampled UART receiver (8N1) with a 4-character history for the
// 7-segment path. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int         TICK_DIV  = TICK_DIV_DEF,
  parameter int         OVS       = OVS_DEF,
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iCE,
  input  logic       iDatos,
  output logic [7:0] ovCarga0,
  output logic [7:0] ovCarga1,
  output logic [7:0] ovCarga2,
  output logic [7:0] ovCarga3,
  output logic [7:0] ovData,
  output logic       oValid,
  output logic       oFrameErr,
  output logic       oBusy
);

  localparam int            SW   = $clog2(OVS);
  localparam logic [SW-1:0] MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVS - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

  rx_state_e     state;
  logic          prev;
  logic [SW-1:0] scnt;
  logic [2:0]    bidx;
  logic [7:0]    sh;
  logic          tick;
  logic          edge_det;
  logic          par_bad;

  // Start edge re-phases the tick counter so samples land mid-bit.
  assign edge_det = (state == ST_IDLE) && prev && !iDatos;

  uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (iClk),
    .rst_n (iReset),
    .ce    (iCE),
    .clr   (edge_det),
    .tick  (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_err;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset)                                        par_err <= 1'b0;
    else if (iCE && tick && state == ST_PARITY && scnt == LAST)
                                                        par_err <= even_par_err(sh, iDatos);
  end

  assign par_bad = par_err;
`else
  assign par_bad = 1'b0;
`endif

  assign oBusy = (state != ST_IDLE);

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state     <= ST_IDLE;
      prev      <= 1'b0;
      scnt      <= '0;
      bidx      <= '0;
      sh        <= '0;
      ovCarga0  <= IDLE_CHAR;
      ovCarga1  <= IDLE_CHAR;
      ovCarga2  <= IDLE_CHAR;
      ovCarga3  <= IDLE_CHAR;
      ovData    <= '0;
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
      if (iCE) begin
        prev <= iDatos;
        case (state)
          ST_IDLE: if (edge_det) begin
            state <= ST_START;
            scnt  <= '0;
          end
          ST_START: if (tick) begin
            if (scnt == MID) begin
              scnt <= '0;
              bidx <= '0;
              state <= iDatos ? ST_IDLE : ST_DATA;
            end else scnt <= scnt + 1'b1;
          end
          ST_DATA: if (tick) begin
            if (scnt == LAST) begin
              scnt <= '0;
              sh   <= {iDatos, sh[7:1]};
              bidx <= bidx + 3'd1;
              if (bidx == 3'd7) state <= AFTER_DATA;
            end else scnt <= scnt + 1'b1;
          end
          ST_PARITY: if (tick) begin
            if (scnt == LAST) begin
              scnt  <= '0;
              state <= ST_STOP;
            end else scnt <= scnt + 1'b1;
          end
          ST_STOP: if (tick) begin
            if (scnt == LAST) begin
              scnt <= '0;
              if (!iDatos) begin
                oFrameErr <= 1'b1;
                state     <= ST_BREAK;
              end else if (par_bad) begin
                oFrameErr <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                ovCarga3 <= ovCarga2;
                ovCarga2 <= ovCarga1;
                ovCarga1 <= ovCarga0;
                ovCarga0 <= sh;
                ovData   <= sh;
                oValid   <= 1'b1;
                state    <= ST_IDLE;
              end
            end else scnt <= scnt + 1'b1;
          end
          // Held-low line: one error pulse, then wait for the line to recover.
          ST_BREAK: if (iDatos) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Randomized self-checking bench for uart_rx_ovs: frames are queued as
// expected events and every cycle the outputs are compared with a history model.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  localparam int TD  = 5;
  localparam int OVS = 16;
  localparam int B   = TD * OVS;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB     = 10;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB     = 9;
`endif
  // clocks from start-bit drive (negedge) to the negedge after the pulse
  localparam int LAT = (NB * OVS + OVS / 2) * TD + 1;

  logic       iClk = 1'b0;
  logic       iReset, iCE, iDatos;
  logic [7:0] ovCarga0, ovCarga1, ovCarga2, ovCarga3, ovData;
  logic       oValid, oFrameErr, oBusy;

  uart_rx_ovs #(.TICK_DIV(TD), .OVS(OVS), .IDLE_CHAR(8'h20)) dut (
    .iClk(iClk), .iReset(iReset), .iCE(iCE), .iDatos(iDatos),
    .ovCarga0(ovCarga0), .ovCarga1(ovCarga1), .ovCarga2(ovCarga2), .ovCarga3(ovCarga3),
    .ovData(ovData), .oValid(oValid), .oFrameErr(oFrameErr), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    bit         ok;
    logic [7:0] d;
    longint     t0;
    bit         lat;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] hist [4];
  logic [7:0] mdata;
  int         errs = 0, checks = 0;
  bit         ce_rand = 1'b0;
  bit         pv = 1'b0, pf = 1'b0;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Hold the line at v for n clock-enabled cycles; called and returns at a negedge.
  task automatic hold(input logic v, input int n);
    int c = 0;
    iDatos = v;
    while (c < n) begin
      if (iCE) c++;
      @(negedge iClk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok, input bit lat);
    ev_t e;
    e.ok  = stop && (!PAR_EN || par_ok);
    e.d   = d;
    e.t0  = longint'($time);
    e.lat = lat;
    evq.push_back(e);
    hold(1'b0, B);
    chk("busy_in_frame", {7'd0, oBusy}, 8'd1);
    for (int i = 0; i < 8; i++) hold(d[i], B);
    if (PAR_EN) hold(par_ok ? ^d : ~^d, B);
    hold(stop, B);
  endtask

  // clock enable changes just after posedge so it is stable for the driver
  initial begin
    iCE = 1'b1;
    forever begin
      @(posedge iClk);
      #1 iCE = ce_rand ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Reference model and per-cycle compare
  initial begin
    ev_t    e;
    longint dt;
    for (int i = 0; i < 4; i++) hist[i] = 8'h20;
    mdata = 8'h00;
    forever begin
      @(negedge iClk);
      if (iReset !== 1'b1) begin
        for (int i = 0; i < 4; i++) hist[i] = 8'h20;
        mdata = 8'h00;
        evq.delete();
        checks++;
        if ({oValid, oFrameErr, oBusy} !== 3'b000) begin
          errs++;
          $display("FAIL reset_flags got=%b exp=000", {oValid, oFrameErr, oBusy});
        end
      end else begin
        if (oValid === 1'b1 || oFrameErr === 1'b1) begin
          checks++;
          if ((oValid && pv) || (oFrameErr && pf) || (oValid && oFrameErr)) begin
            errs++;
            $display("FAIL pulse_shape valid=%b ferr=%b prev=%b%b", oValid, oFrameErr, pv, pf);
          end else if (evq.size() == 0) begin
            errs++;
            $display("FAIL unexpected_pulse valid=%b ferr=%b exp=none", oValid, oFrameErr);
          end else begin
            e = evq.pop_front();
            if (oValid !== e.ok) begin
              errs++;
              $display("FAIL pulse_kind valid=%b exp_valid=%b byte=%h", oValid, e.ok, e.d);
            end
            if (e.ok) begin
              hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = e.d;
              mdata = e.d;
            end
            if (e.lat) begin
              checks++;
              dt = longint'($time) - e.t0;
              if (dt < longint'(LAT * 10 - 10) || dt > longint'(LAT * 10 + 10)) begin
                errs++;
                $display("FAIL latency got=%0d exp=%0d ns", dt, LAT * 10);
              end
            end
          end
        end
      end
      pv = (oValid === 1'b1);
      pf = (oFrameErr === 1'b1);
      checks++;
      if ({ovCarga3, ovCarga2, ovCarga1, ovCarga0, ovData} !== {hist[3], hist[2], hist[1], hist[0], mdata}) begin
        errs++;
        $display("FAIL history got=%h %h %h %h d=%h exp=%h %h %h %h d=%h",
                 ovCarga3, ovCarga2, ovCarga1, ovCarga0, ovData,
                 hist[3], hist[2], hist[1], hist[0], mdata);
      end
    end
  end

  initial begin
    #900000;
    errs++;
    $display("FAIL watchdog time=%0t exp=finish", $time);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

  initial begin
    int gap;
    bit stop;
    iReset = 1'b0;
    iDatos = 1'b1;
    repeat (3) @(negedge iClk);
    chk("rst_carga0", ovCarga0, 8'h20);
    chk("rst_carga3", ovCarga3, 8'h20);
    chk("rst_data",   ovData,   8'h00);
    @(posedge iClk);
    #2 iReset = 1'b1;
    @(negedge iClk);

    hold(1'b1, 2 * B);
    chk("idle_busy",   {7'd0, oBusy}, 8'd0);
    chk("idle_carga0", ovCarga0, 8'h20);

    send_frame(8'h48, 1'b1, 1'b1, 1'b1);
    send_frame(8'h4F, 1'b1, 1'b1, 1'b1);
    send_frame(8'h4C, 1'b1, 1'b1, 1'b1);
    send_frame(8'h41, 1'b1, 1'b1, 1'b1);
    hold(1'b1, B);
    chk("hola_c0", ovCarga0, 8'h41);
    chk("hola_c1", ovCarga1, 8'h4C);
    chk("hola_c2", ovCarga2, 8'h4F);
    chk("hola_c3", ovCarga3, 8'h48);
    chk("hola_d",  ovData,   8'h41);

    hold(1'b0, 4 * TD);
    hold(1'b1, 2 * B);
    chk("glitch_busy", {7'd0, oBusy}, 8'd0);
    chk("glitch_c0",   ovCarga0, 8'h41);

    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    hold(1'b0, 3 * B);
    hold(1'b1, B);
    chk("brk_c0", ovCarga0, 8'h41);
    send_frame(8'h31, 1'b1, 1'b1, 1'b1);
    hold(1'b1, B);
    chk("after_brk_c0", ovCarga0, 8'h31);
    chk("after_brk_c1", ovCarga1, 8'h41);

    // partial 0x7E: start, bits 0..2, half of bit 3, then reset
    hold(1'b0, B);
    hold(1'b0, B);
    hold(1'b1, B);
    hold(1'b1, B);
    hold(1'b1, B / 2);
    @(posedge iClk);
    #2 iReset = 1'b0;
    #1;
    chk("mid_rst_c0",   ovCarga0, 8'h20);
    chk("mid_rst_c1",   ovCarga1, 8'h20);
    chk("mid_rst_busy", {7'd0, oBusy}, 8'd0);
    iDatos = 1'b1;
    repeat (3) @(posedge iClk);
    #2 iReset = 1'b1;
    @(negedge iClk);
    hold(1'b1, B);
    send_frame(8'h33, 1'b1, 1'b1, 1'b1);
    hold(1'b1, B);
    chk("post_rst_c0", ovCarga0, 8'h33);
    chk("post_rst_c1", ovCarga1, 8'h20);

    if (PAR_EN) begin
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      hold(1'b1, B);
      chk("par_c0", ovCarga0, 8'h03);
      chk("par_c1", ovCarga1, 8'h33);
    end

    ce_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      stop = ($urandom_range(7) != 0);
      send_frame(8'($urandom), stop, ($urandom_range(5) != 0), 1'b0);
      gap = stop ? $urandom_range(2) : 1 + $urandom_range(1);
      hold(1'b1, gap * B / 2);
    end
    ce_rand = 1'b0;
    hold(1'b1, 2 * B);

    checks++;
    if (evq.size() != 0) begin
      errs++;
      $display("FAIL pending_events got=%0d exp=0", evq.size());
    end
    chk("end_busy", {7'd0, oBusy}, 8'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
